// File: rtl/lut_sweep_gen_if.sv
// Control/ROM bus of the cosine-LUT address sequencer: configuration and run
// control from the modulator registers, ROM address/data, and the sample stream.
interface lut_sweep_gen_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 15,
  parameter int DIV_W  = 16
);
  logic              run;
  logic              cfg_load;
  logic [DIV_W-1:0]  cfg_div;
  logic [ADDR_W-1:0] cfg_start;
  logic [ADDR_W-1:0] cfg_end;
  logic [ADDR_W-1:0] cfg_step;
  logic [1:0]        cfg_mode;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              done;
  logic              busy;

  modport master (
    output run, cfg_load, cfg_div, cfg_start, cfg_end, cfg_step, cfg_mode, rom_q,
    input  rom_addr, sample, sample_valid, done, busy
  );

  modport slave (
    input  run, cfg_load, cfg_div, cfg_start, cfg_end, cfg_step, cfg_mode, rom_q,
    output rom_addr, sample, sample_valid, done, busy
  );
endinterface

// File: rtl/lut_sweep_gen.sv
// Cosine-ROM address sequencer: prescaled tick, windowed wrap/one-shot/ping-pong
// address stepping, and a fetch-strobe pipeline that realigns ROM data to a strobe.
module lut_sweep_gen #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 15,
  parameter int DIV_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  lut_sweep_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] step_q;
  mode_e             mode_q;
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              busy_q;

  logic              tick;
  logic              adv;
  logic              at_end;
  logic              fetch;
  logic [ADDR_W:0]   sum_up;
  logic [ADDR_W:0]   lo_lim;
  logic [ADDR_W-1:0] wrap_next;
  logic [ADDR_W-1:0] os_next;

  logic [ROM_LAT:0]  vld_p;
  logic [DATA_W-1:0] sample_q;
  logic              sample_valid_q;

  // Clamp an extended sum to the window top; sums carry one extra bit so a
  // large step can never alias back into the window.
  function automatic logic [ADDR_W-1:0] clamp_hi(input logic [ADDR_W:0] sum,
                                                 input logic [ADDR_W-1:0] hi);
    if (sum >= {1'b0, hi}) return hi;
    else                   return sum[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_lo(input logic [ADDR_W:0] sum,
                                                input logic [ADDR_W-1:0] lo,
                                                input logic [ADDR_W-1:0] hi);
    if (sum > {1'b0, hi}) return lo;
    else                  return sum[ADDR_W-1:0];
  endfunction

  always_comb begin
    sum_up    = {1'b0, addr_q} + {1'b0, step_q};
    lo_lim    = {1'b0, start_q} + {1'b0, step_q};
    at_end    = (addr_q == end_q);
    tick      = bus.run && (cnt_q == div_q);
    adv       = tick && (state_q != ST_DONE);
    wrap_next = wrap_lo(sum_up, start_q, end_q);
    os_next   = clamp_hi(sum_up, end_q);
    // A one-shot tick that lands on the end only retires the sequence.
    fetch     = bus.cfg_load || (adv && !((mode_q == MODE_ONESHOT) && at_end));
  end

  // Stage p0: prescaler, configuration and address/direction state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= '0;
      start_q <= '0;
      end_q   <= '1;
      step_q  <= ADDR_W'(1);
      mode_q  <= MODE_WRAP;
      state_q <= ST_UP;
      addr_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (bus.cfg_load)  cnt_q <= '0;
      else if (tick)     cnt_q <= '0;
      else if (bus.run)  cnt_q <= cnt_q + DIV_W'(1);

      busy_q <= bus.run && (state_q != ST_DONE);

      if (bus.cfg_load) begin
        div_q   <= bus.cfg_div;
        start_q <= bus.cfg_start;
        end_q   <= (bus.cfg_start > bus.cfg_end) ? bus.cfg_start : bus.cfg_end;
        step_q  <= bus.cfg_step;
        mode_q  <= mode_e'(bus.cfg_mode);
        addr_q  <= bus.cfg_start;
        state_q <= ST_UP;
        done_q  <= 1'b0;
        busy_q  <= bus.run;
      end else if (adv) begin
        case (mode_q)
          MODE_ONESHOT: begin
            if (at_end) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              addr_q <= os_next;
            end
          end
          MODE_PINGPONG: begin
            if (state_q == ST_UP) begin
              if (sum_up >= {1'b0, end_q}) begin
                addr_q  <= end_q;
                state_q <= ST_DOWN;
              end else begin
                addr_q <= sum_up[ADDR_W-1:0];
              end
            end else begin
              if ({1'b0, addr_q} < lo_lim) begin
                addr_q  <= start_q;
                state_q <= ST_UP;
              end else begin
                addr_q <= addr_q - step_q;
              end
            end
          end
          default: addr_q <= wrap_next;
        endcase
      end
    end
  end

  // Stage p1..p(ROM_LAT+1): fetch strobe follows the ROM latency, then data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      vld_p          <= {vld_p[ROM_LAT-1:0], fetch};
      sample_valid_q <= vld_p[ROM_LAT];
      if (vld_p[ROM_LAT]) sample_q <= bus.rom_q;
    end
  end

  assign bus.rom_addr     = addr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule
